uart_rx_engine: RTL and testbench

Serial receive front end of the PicoBlaze SoC UART. It recovers asynchronous frames on `rx` using the same runtime frame controls the SoC exposes: `bit8`, `parity_en`, `odd_n_even` and `baud_val`. It presents each received character and its error flags to the processor port logic through a sticky ready flag that a read strobe clears. The block sits directly upstream of the PicoBlaze input port mux and feeds it one byte per frame.

---
 rtl/uart_rx_engine.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// Purpose: PicoBlaze UART serial receiver (2-FF synced rx, 7/8 data bits, optional parity, runtime baud select).
// Latency: rx_ready rises 1 clk after the stop-bit sample (~9.5*BT+3 clks from the pin edge for 8N1).
// Backpressure: none; sticky rx_ready is cleared by rx_rd, an unread character is overwritten and ovf is set.
// Option: define RX_MAJORITY_VOTE_EN for 2-of-3 sampling per bit (adds 1 clk to the decision and commit).
module uart_rx_engine #(
  parameter int CLK_FREQ_HZ = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic [3:0] baud_val,
  input  logic       rx_rd,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       perr,
  output logic       ferr,
  output logic       ovf,
  output logic       rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Bit time in clocks, rounded to nearest, for a given baud select code.
  function automatic logic [18:0] bit_time(input logic [3:0] sel);
    int baud;
    case (sel)
      4'd0:    baud = 300;
      4'd1:    baud = 1200;
      4'd2:    baud = 2400;
      4'd3:    baud = 4800;
      4'd4:    baud = 9600;
      4'd5:    baud = 19200;
      4'd6:    baud = 38400;
      4'd7:    baud = 57600;
      4'd8:    baud = 115200;
      4'd9:    baud = 230400;
      4'd10:   baud = 460800;
      default: baud = 921600;
    endcase
    bit_time = 19'((CLK_FREQ_HZ + baud / 2) / baud);
  endfunction

  state_t      state, state_n;
  logic        rx_meta, rxs, rxs_d;
  logic [18:0] cnt;
  logic [18:0] bt_live, bt_frame, half_bt;
  logic        bit8_q, par_en_q, odd_q;
  logic [3:0]  baud_q;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        par_acc;
  logic        perr_frm;
  logic        start_edge, expire, last_bit, commit;
  logic        samp_vld, samp_bit;
  logic [7:0]  frame_data;

  // The start edge uses the live baud select; the rest of the frame uses the latched copy.
  assign bt_live    = bit_time(baud_val);
  assign bt_frame   = bit_time(baud_q);
  assign half_bt    = bt_live >> 1;
  assign start_edge = (state == IDLE) && rxs_d && !rxs;
  assign expire     = (state != IDLE) && (cnt == 19'd0);
  assign last_bit   = (bit_idx == (bit8_q ? 3'd7 : 3'd6));
  assign frame_data = bit8_q ? shreg : {1'b0, shreg[7:1]};
  assign rx_busy    = (state != IDLE);

`ifdef RX_MAJORITY_VOTE_EN
  logic vote_c1, vote_c0, vote_pend;

  // Capture rxs at counter 1 and 0; the third vote is the live rxs in the cycle after expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vote_c1   <= 1'b1;
      vote_c0   <= 1'b1;
      vote_pend <= 1'b0;
    end else begin
      if (state != IDLE && cnt == 19'd1) vote_c1 <= rxs;
      if (expire)                        vote_c0 <= rxs;
      vote_pend <= expire;
    end
  end

  assign samp_vld = vote_pend;
  assign samp_bit = (vote_c1 & vote_c0) | (vote_c1 & rxs) | (vote_c0 & rxs);
`else
  assign samp_vld = expire;
  assign samp_bit = rxs;
`endif

  // Two-flop synchronizer plus a delayed copy for falling-edge detection; idle level is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; commit is the stop-bit decision cycle.
  always_comb begin
    state_n = state;
    commit  = 1'b0;
    case (state)
      IDLE:   if (start_edge) state_n = START;
      START:  if (samp_vld) state_n = samp_bit ? IDLE : DATA;
      DATA:   if (samp_vld && last_bit) state_n = par_en_q ? PARITY : STOP;
      PARITY: if (samp_vld) state_n = STOP;
      STOP: begin
        if (samp_vld) begin
          state_n = IDLE;
          commit  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Bit timer, frame config latch, data shifter and running parity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= 19'd0;
      bit8_q   <= 1'b0;
      par_en_q <= 1'b0;
      odd_q    <= 1'b0;
      baud_q   <= 4'd0;
      shreg    <= 8'd0;
      bit_idx  <= 3'd0;
      par_acc  <= 1'b0;
      perr_frm <= 1'b0;
    end else begin
      if (start_edge) begin
        cnt      <= half_bt - 19'd1;
        bit8_q   <= bit8;
        par_en_q <= parity_en;
        odd_q    <= odd_n_even;
        baud_q   <= baud_val;
        bit_idx  <= 3'd0;
        par_acc  <= 1'b0;
        perr_frm <= 1'b0;
      end else if (state != IDLE) begin
        cnt <= (cnt == 19'd0) ? (bt_frame - 19'd1) : (cnt - 19'd1);
      end
      if (samp_vld && state == DATA) begin
        shreg   <= {samp_bit, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
        par_acc <= par_acc ^ samp_bit;
      end
      if (samp_vld && state == PARITY) begin
        perr_frm <= par_acc ^ samp_bit ^ odd_q;
      end
    end
  end

  // Output holding register: commit beats a coincident read; read clears flags but keeps data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data  <= 8'd0;
      rx_ready <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      ovf      <= 1'b0;
    end else if (commit) begin
      rx_data  <= frame_data;
      perr     <= perr_frm;
      ferr     <= ~samp_bit;
      ovf      <= rx_ready & ~rx_rd;
      rx_ready <= 1'b1;
    end else if (rx_rd && rx_ready) begin
      rx_ready <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      ovf      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: drives UART frames cycle by cycle and compares against a frame-level model.
// The design runs at a 20 MHz parameter so 9600-baud frames stay short in clock cycles.
// Build with RX_MAJORITY_VOTE_EN to add the mid-bit spike rejection check.
module tb_uart_rx_engine;

  localparam int CLK_HZ = 20000000;
`ifdef RX_MAJORITY_VOTE_EN
  localparam int VOTE_LAT = 1;
`else
  localparam int VOTE_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       bit8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       odd_n_even = 1'b0;
  logic [3:0] baud_val = 4'd4;
  logic       rx_rd = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready, perr, ferr, ovf, rx_busy;

  uart_rx_engine #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .clk(clk), .reset(reset), .rx(rx), .bit8(bit8), .parity_en(parity_en),
    .odd_n_even(odd_n_even), .baud_val(baud_val), .rx_rd(rx_rd),
    .rx_data(rx_data), .rx_ready(rx_ready), .perr(perr), .ferr(ferr),
    .ovf(ovf), .rx_busy(rx_busy)
  );

  always #25 clk = ~clk;

  // Model state: expected outputs plus the scheduled events of the frame in flight.
  int         cyc = 0;
  int         pend_on = -1, pend_off = -1, pend_commit = -1;
  logic [7:0] pend_data = 8'd0;
  logic       pend_perr = 1'b0, pend_ferr = 1'b0;
  logic [7:0] exp_data = 8'd0;
  logic       exp_ready = 1'b0, exp_perr = 1'b0, exp_ferr = 1'b0, exp_ovf = 1'b0, exp_busy = 1'b0;
  int         n_chk = 0, n_fail = 0;

  function automatic int bt_for(input logic [3:0] sel);
    int baud;
    case (sel)
      4'd0: baud = 300;     4'd1: baud = 1200;    4'd2: baud = 2400;    4'd3: baud = 4800;
      4'd4: baud = 9600;    4'd5: baud = 19200;   4'd6: baud = 38400;   4'd7: baud = 57600;
      4'd8: baud = 115200;  4'd9: baud = 230400;  4'd10: baud = 460800; default: baud = 921600;
    endcase
    return (CLK_HZ + baud / 2) / baud;
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %02h, want %02h", name, got, want);
    end
  endtask

  task automatic model_step();
    cyc++;
    if (!reset) begin
      exp_data = 8'd0; exp_ready = 1'b0; exp_perr = 1'b0;
      exp_ferr = 1'b0; exp_ovf = 1'b0; exp_busy = 1'b0;
    end else begin
      if (cyc == pend_on)  exp_busy = 1'b1;
      if (cyc == pend_off) exp_busy = 1'b0;
      if (cyc == pend_commit) begin
        exp_ovf   = exp_ready && !rx_rd;
        exp_ready = 1'b1;
        exp_data  = pend_data;
        exp_perr  = pend_perr;
        exp_ferr  = pend_ferr;
      end else if (rx_rd && exp_ready) begin
        exp_ready = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0; exp_ovf = 1'b0;
      end
    end
  endtask

  // One clock: update the model at the edge, compare shortly after it, return on the falling edge.
  task automatic tick();
    logic [12:0] got_v, exp_v;
    @(posedge clk);
    model_step();
    #2;
    got_v = {rx_busy, rx_ready, perr, ferr, ovf, rx_data};
    exp_v = {exp_busy, exp_ready, exp_perr, exp_ferr, exp_ovf, exp_data};
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_outputs cyc=%0d got busy=%0b rdy=%0b perr=%0b ferr=%0b ovf=%0b data=%02h, want busy=%0b rdy=%0b perr=%0b ferr=%0b ovf=%0b data=%02h",
               cyc, rx_busy, rx_ready, perr, ferr, ovf, rx_data,
               exp_busy, exp_ready, exp_perr, exp_ferr, exp_ovf, exp_data);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic read_pulse();
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
    tick();
  endtask

  // Drive one frame using the current config inputs. abort_slots>0 stops after that many bit slots
  // without scheduling a commit; spike_n>=0 inverts rx for one clock at the middle of slot spike_n.
  task automatic send_frame(input logic [7:0] d, input bit pbit, input bit stopb,
                            input int spike_n, input bit rd_commit, input int abort_slots);
    int bt, half, ndata, nbits, c, lim;
    logic [11:0] fb;
    logic [7:0]  dm;
    bt    = bt_for(baud_val);
    half  = bt / 2;
    ndata = bit8 ? 8 : 7;
    nbits = 2 + ndata + (parity_en ? 1 : 0);
    fb    = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < ndata; i++) fb[1 + i] = d[i];
    if (parity_en) fb[1 + ndata] = pbit;
    fb[nbits - 1] = stopb;
    c = cyc;
    pend_on = c + 3;
    if (abort_slots == 0) begin
      dm          = bit8 ? d : {1'b0, d[6:0]};
      pend_off    = c + 3 + half + (nbits - 1) * bt + VOTE_LAT;
      pend_commit = pend_off;
      pend_data   = dm;
      pend_ferr   = !stopb;
      pend_perr   = parity_en && ((($countones(dm) + int'(pbit)) % 2) != (odd_n_even ? 1 : 0));
      lim         = nbits * bt;
    end else begin
      pend_off    = -1;
      pend_commit = -1;
      lim         = abort_slots * bt;
    end
    for (int k = 0; k < lim; k++) begin
      logic b;
      b = fb[k / bt];
      if (spike_n >= 0 && k == half + spike_n * bt) b = ~b;
      rx = b;
      if (rd_commit) rx_rd = (cyc == pend_commit - 1);
      tick();
    end
    rx    = 1'b1;
    rx_rd = 1'b0;
  endtask

  task automatic glitch(input int len);
    int half;
    half        = bt_for(baud_val) / 2;
    pend_on     = cyc + 3;
    pend_off    = cyc + 3 + half + VOTE_LAT;
    pend_commit = -1;
    rx = 1'b0;
    idle(len);
    rx = 1'b1;
  endtask

  initial begin
    #5 reset = 1'b0;
    tick();
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_ready", rx_ready, 8'h0);
    check("reset_perr", perr, 8'h0);
    check("reset_ferr", ferr, 8'h0);
    check("reset_ovf", ovf, 8'h0);
    check("reset_rx_busy", rx_busy, 8'h0);
    tick();
    reset = 1'b1;
    idle(4);

    // 8N1 0x41 at 9600.
    baud_val = 4'd4; bit8 = 1'b1; parity_en = 1'b0;
    send_frame(8'h41, 1'b0, 1'b1, -1, 1'b0, 0);
    idle(10);
    check("f41_data", rx_data, 8'h41);
    check("f41_ready", rx_ready, 8'h1);
    check("f41_flags", {perr, ferr, ovf}, 8'h0);
    read_pulse();
    check("f41_rd_ready", rx_ready, 8'h0);
    check("f41_rd_data_held", rx_data, 8'h41);

    // Even parity at 921600: wrong then right parity bit.
    baud_val = 4'd11; parity_en = 1'b1; odd_n_even = 1'b0;
    send_frame(8'h41, 1'b1, 1'b1, -1, 1'b0, 0);
    idle(10);
    check("even_bad_data", rx_data, 8'h41);
    check("even_bad_perr", perr, 8'h1);
    read_pulse();
    send_frame(8'h43, 1'b1, 1'b1, -1, 1'b0, 0);
    idle(10);
    check("even_good_data", rx_data, 8'h43);
    check("even_good_perr", perr, 8'h0);
    read_pulse();

    // 7-bit odd parity, then a low stop bit.
    bit8 = 1'b0; odd_n_even = 1'b1;
    send_frame(8'h7F, 1'b0, 1'b1, -1, 1'b0, 0);
    idle(10);
    check("odd7_data", rx_data, 8'h7F);
    check("odd7_perr", perr, 8'h0);
    check("odd7_ferr", ferr, 8'h0);
    read_pulse();
    send_frame(8'h7F, 1'b0, 1'b0, -1, 1'b0, 0);
    idle(10);
    check("stop_low_ferr", ferr, 8'h1);
    read_pulse();
    idle(50);

    // Back-to-back 8N1 frames: overrun, then a read coinciding with the second commit.
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    send_frame(8'h55, 1'b0, 1'b1, -1, 1'b0, 0);
    send_frame(8'hAA, 1'b0, 1'b1, -1, 1'b0, 0);
    idle(10);
    check("ovf_data", rx_data, 8'hAA);
    check("ovf_set", ovf, 8'h1);
    read_pulse();
    check("ovf_cleared_by_rd", ovf, 8'h0);
    send_frame(8'h55, 1'b0, 1'b1, -1, 1'b0, 0);
    send_frame(8'hAA, 1'b0, 1'b1, -1, 1'b1, 0);
    idle(10);
    check("rd_commit_ovf", ovf, 8'h0);
    check("rd_commit_ready", rx_ready, 8'h1);
    check("rd_commit_data", rx_data, 8'hAA);
    read_pulse();

    // False start: 2000 ns low glitch at 9600.
    baud_val = 4'd4;
    glitch(40);
    check("glitch_busy_high", rx_busy, 8'h1);
    idle(bt_for(4'd4) / 2 + 10);
    check("glitch_busy_low", rx_busy, 8'h0);
    check("glitch_ready", rx_ready, 8'h0);
    baud_val = 4'd11;
    idle(20);

`ifdef RX_MAJORITY_VOTE_EN
    // One-clock spike on the mid-bit sample of data bit 3.
    send_frame(8'h41, 1'b0, 1'b1, 4, 1'b0, 0);
    idle(10);
    check("vote_spike_data", rx_data, 8'h41);
    read_pulse();
`endif

    // Reset mid-byte after data bit 4, then a clean frame.
    send_frame(8'h41, 1'b0, 1'b1, -1, 1'b0, 6);
    reset = 1'b0;
    #1;
    check("abort_outputs", {rx_busy, rx_ready, perr, ferr, ovf}, 8'h00);
    check("abort_data", rx_data, 8'h00);
    tick();
    tick();
    reset = 1'b1;
    idle(20);
    send_frame(8'h41, 1'b0, 1'b1, -1, 1'b0, 0);
    idle(10);
    check("post_abort_data", rx_data, 8'h41);
    check("post_abort_ready", rx_ready, 8'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
